// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage. Holds the program counter, drives the instruction
// memory read and presents the fetched word to the IF/ID register. A taken
// branch/jump redirects the PC; a committed halt stops fetch until reset.
//
// Optional feature (macro FETCH_SKID_BUF_EN):
//   defined   - a one-entry skid buffer catches a word returned while IF/ID is
//               stalled, and fetch parks in HOLD with the memory read disabled.
//   undefined - no buffer; on an IF/ID stall the PC holds and memory is simply
//               re-read, so imemload is re-presented on later cycles.
//
// Parameters:
//   RESET_PC       PC loaded on reset (low two bits forced to zero)
//
// Ports:
//   CLK            clock, rising edge
//   RST            asynchronous active-high reset
//   ihit           imemload is valid this cycle
//   imemload       instruction word from memory
//   enable_IF_ID   IF/ID accepts the presented instruction this cycle
//   redirect       taken branch/jump, load PC from redirect_addr
//   redirect_addr  redirect target (word aligned on load)
//   halt           halt committed, fetch stops until reset
//   iREN           instruction memory read enable
//   imemaddr       current PC
//   instruction    word presented to IF/ID
//   next_imemaddr  imemaddr + 4 (wrapping)
//   valid_IF       instruction/imemaddr/next_imemaddr hold a valid fetch
// -----------------------------------------------------------------------------
// state  | meaning
// FETCH  | reading memory at PC, word passes straight through on ihit
// HOLD   | IF/ID stalled, captured word replayed from buffer, memory idle
//          (present only with FETCH_SKID_BUF_EN)
// HALTED | halt committed, no fetch, left only through reset
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        enable_IF_ID,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        halt,
  output logic        iREN,
  output logic [31:0] imemaddr,
  output logic [31:0] instruction,
  output logic [31:0] next_imemaddr,
  output logic        valid_IF
);

`ifdef FETCH_SKID_BUF_EN
  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HALTED = 2'd2
  } state_t;
`endif

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state;
  logic [29:0] pc_word;      // PC[31:2]; PC[1:0] is constant zero
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect_take;

  assign pc       = {pc_word, 2'b00};
  assign pc_plus4 = pc + 32'd4;

  // halt wins over redirect; a redirect is ignored once halted
  assign redirect_take = redirect && !halt && (state != HALTED);

`ifdef FETCH_SKID_BUF_EN
  logic [31:0] buffer;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_word <= RESET_PC_ALIGNED[31:2];
      state   <= FETCH;
`ifdef FETCH_SKID_BUF_EN
      buffer  <= 32'h0000_0000;
`endif
    end else if (halt) begin
      state <= HALTED;
    end else if (redirect_take) begin
      // in-flight ihit and any buffered word are dropped
      pc_word <= redirect_addr[31:2];
      state   <= FETCH;
`ifdef FETCH_SKID_BUF_EN
      buffer  <= 32'h0000_0000;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (ihit && enable_IF_ID) begin
            pc_word <= pc_plus4[31:2];
          end
`ifdef FETCH_SKID_BUF_EN
          else if (ihit) begin
            buffer <= imemload;
            state  <= HOLD;
          end
`endif
        end
`ifdef FETCH_SKID_BUF_EN
        HOLD: begin
          if (enable_IF_ID) begin
            pc_word <= pc_plus4[31:2];
            state   <= FETCH;
          end
        end
`endif
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  // Output decode. Outputs are combinational so valid_IF follows ihit with
  // zero latency; reset and halt gate them immediately.
  always_comb begin
    iREN        = 1'b0;
    valid_IF    = 1'b0;
    instruction = imemload;
    case (state)
      FETCH: begin
        iREN     = 1'b1;
        valid_IF = ihit;
      end
`ifdef FETCH_SKID_BUF_EN
      HOLD: begin
        instruction = buffer;
        valid_IF    = 1'b1;
      end
`endif
      default: begin
        iREN     = 1'b0;
        valid_IF = 1'b0;
      end
    endcase
    if (halt) begin
      iREN     = 1'b0;
      valid_IF = 1'b0;
    end
    if (redirect_take) begin
      valid_IF = 1'b0;
    end
    if (RST) begin
      iREN        = 1'b0;
      valid_IF    = 1'b0;
      instruction = 32'h0000_0000;
    end
  end

  assign imemaddr      = pc;
  assign next_imemaddr = pc_plus4;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 ihit  input  1  instruction memory returns valid imemload this cycle.
REQ-005 imemload  input  32  instruction word from instruction memory.
REQ-006 enable_IF_ID  input  1  IF/ID register accepts the presented instruction this cycle.
REQ-007 redirect  input  1  branch/jump resolved taken; PC must change to redirect_addr.
REQ-008 redirect_addr  input  32  redirect target address.
REQ-009 halt  input  1  halt instruction committed; fetch stops permanently.
REQ-010 iREN  output  1  instruction memory read enable.
REQ-011 imemaddr  output  32  current PC; address of the presented instruction.
REQ-012 instruction  output  32  instruction word presented to IF/ID.
REQ-013 next_imemaddr  output  32  imemaddr + 4, modulo 2^32.
REQ-014 valid_IF  output  1  instruction/imemaddr/next_imemaddr hold a valid fetch.

Function
REQ-015 The block SHALL implement states FETCH, HOLD and HALTED; FETCH is entered on reset.
REQ-016 FETCH: iREN=1, imemaddr=PC, instruction=imemload, valid_IF=ihit (combinational, zero-cycle latency from ihit).
REQ-017 FETCH, ihit=1, enable_IF_ID=1: PC<=PC+4 on the next edge; state stays FETCH.
REQ-018 FETCH, ihit=1, enable_IF_ID=0: imemload captured into a 32-bit buffer; state->HOLD; PC unchanged.
REQ-019 FETCH, ihit=0: PC and state unchanged; valid_IF=0.
REQ-020 HOLD: iREN=0, instruction=buffer, valid_IF=1; on enable_IF_ID=1, PC<=PC+4 and state->FETCH, else remain in HOLD.
REQ-021 redirect=1 (halt=0), any state except HALTED: valid_IF forced 0 that cycle; PC<={redirect_addr[31:2],2'b00}; buffer discarded; state->FETCH; the in-flight ihit is ignored.
REQ-022 halt=1, any state: valid_IF=0 and iREN=0 that cycle; state->HALTED; PC frozen; halt overrides a simultaneous redirect.
REQ-023 HALTED: iREN=0, valid_IF=0, PC frozen; HALTED is exited only by RST.
REQ-024 PC arithmetic SHALL be 32-bit unsigned; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 without error.
REQ-025 PC[1:0] SHALL always read 2'b00.
REQ-026 next_imemaddr SHALL equal imemaddr + 4 in every state, including HALTED.

Reset
REQ-027 On RST=1, asynchronously: PC=RESET_PC, state=FETCH, buffer=0.
REQ-028 During RST=1: iREN=0, valid_IF=0, instruction=0, imemaddr=RESET_PC, next_imemaddr=RESET_PC+4.
REQ-029 RST asserted mid-HOLD or mid-HALTED SHALL discard the buffer and restart fetch at RESET_PC on the first edge after RST deasserts.

Configuration
REQ-030 Macro FETCH_SKID_BUF_EN defined: HOLD state and buffer present, behaviour per REQ-018/REQ-020.
REQ-031 FETCH_SKID_BUF_EN undefined: no HOLD state or buffer; FETCH with ihit=1, enable_IF_ID=0 keeps PC, keeps iREN=1 and re-presents imemload on later cycles; valid_IF=ihit.

Verification
REQ-032 Reset release, ihit=1, enable_IF_ID=1 every cycle, RESET_PC=0 -> imemaddr sequence 0x0,0x4,0x8,0xC on successive cycles, valid_IF=1 each cycle.
REQ-033 At PC=0x10, ihit=1, enable_IF_ID=0 for 3 cycles then 1 (macro defined) -> HOLD entered, iREN=0, instruction stays the captured word, PC=0x10 throughout, then PC=0x14.
REQ-034 At PC=0x20 in HOLD, redirect=1, redirect_addr=0x103 -> valid_IF=0 that cycle; next cycle FETCH with imemaddr=0x100, buffer dropped.
REQ-035 halt=1 and redirect=1 same cycle at PC=0x40 -> HALTED, PC stays 0x40, iREN=0, valid_IF=0 for all following cycles until RST.
REQ-036 PC=0xFFFF_FFFC, ihit=1, enable_IF_ID=1 -> next imemaddr=0x0000_0000, next_imemaddr=0x0000_0004.
REQ-037 RST pulsed asynchronously (between edges) while in HOLD -> outputs reach reset values before the next edge; fetch resumes at RESET_PC.
